// File: rtl/freq_meter_pkg.sv
// rtl/freq_meter_pkg.sv - shared types and constants for the frequency meter
package freq_meter_pkg;
  localparam int FREQ_W    = 17;
  localparam int MAX_COUNT = 9999;

  typedef logic [3:0] bcd_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GATE  = 2'd1,
    LATCH = 2'd2
  } state_t;
endpackage

// File: rtl/freq_meter_bcd_digit_counter.sv
// rtl/freq_meter_bcd_digit_counter.sv - mod-10 counter stage with clear, increment-in and carry-out
module bcd_digit_counter
  import freq_meter_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic i_clear,
  input  logic i_inc,
  output bcd_t o_digit,
  output logic o_carry
);
  bcd_t r_digit;

  assign o_carry = i_inc && (r_digit == 4'd9);
  assign o_digit = r_digit;

  always_ff @(posedge clk) begin
    if (!rst_n || i_clear) begin
      r_digit <= '0;
    end else if (i_inc) begin
      r_digit <= o_carry ? 4'd0 : r_digit + 4'd1;
    end
  end
endmodule

// File: rtl/freq_meter.sv
// rtl/freq_meter.sv - gated rising-edge counter reporting binary and BCD frequency
// FREQ_METER_DEGLITCH_EN adds a 3-tap majority filter ahead of edge detection.
module freq_meter
  import freq_meter_pkg::*;
#(
  parameter int GATE_CYCLES = 100_000_000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              sig_in,
  output logic [FREQ_W-1:0] frequency,
  output bcd_t              digit_one,
  output bcd_t              digit_ten,
  output bcd_t              digit_hundred,
  output bcd_t              digit_thousand,
  output logic              overflow,
  output logic              valid
);
  localparam int GATE_W = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);

  logic [1:0]        r_sync;
  logic              r_prev;
  logic              w_level;
  logic              w_edge;
  state_t            r_state;
  state_t            w_next;
  logic [GATE_W-1:0] r_gate_cnt;
  logic [FREQ_W-1:0] r_work;
  logic              r_work_ovf;
  logic              w_count_en;
  logic              w_clear;
  logic              w_sat;
  logic              w_ovf_hit;
  logic [4:0]        w_inc;
  bcd_t              w_digit [4];
  logic [FREQ_W-1:0] r_freq;
  bcd_t              r_digit [4];
  logic              r_ovf;
  logic              r_valid;

  always_ff @(posedge clk) begin
    if (!rst_n) r_sync <= '0;
    else        r_sync <= {r_sync[0], sig_in};
  end

`ifdef FREQ_METER_DEGLITCH_EN
  logic [2:0] r_taps;
  always_ff @(posedge clk) begin
    if (!rst_n) r_taps <= '0;
    else        r_taps <= {r_taps[1:0], r_sync[1]};
  end
  assign w_level = (r_taps[0] & r_taps[1]) | (r_taps[0] & r_taps[2]) | (r_taps[1] & r_taps[2]);
`else
  assign w_level = r_sync[1];
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) r_prev <= 1'b0;
    else        r_prev <= w_level;
  end
  assign w_edge = w_level & ~r_prev;

  assign w_sat = (r_work == FREQ_W'(MAX_COUNT));
  // A thousands carry could only mean the count ran past MAX_COUNT.
  assign w_ovf_hit = (r_state == GATE) && w_edge && (w_sat || w_inc[4]);

  always_comb begin
    w_next     = r_state;
    w_count_en = 1'b0;
    w_clear    = 1'b1;
    case (r_state)
      IDLE:  if (enable) w_next = GATE;
      GATE: begin
        w_clear    = 1'b0;
        w_count_en = w_edge && !w_sat;
        if (!enable)                       w_next = IDLE;
        else if (r_gate_cnt == GATE_LAST)  w_next = LATCH;
      end
      LATCH: w_next = enable ? GATE : IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (!rst_n || r_state != GATE) r_gate_cnt <= '0;
    else                           r_gate_cnt <= r_gate_cnt + GATE_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n || w_clear) begin
      r_work     <= '0;
      r_work_ovf <= 1'b0;
    end else begin
      if (w_count_en) r_work     <= r_work + FREQ_W'(1);
      if (w_ovf_hit)  r_work_ovf <= 1'b1;
    end
  end

  assign w_inc[0] = w_count_en;
  for (genvar gi = 0; gi < 4; gi++) begin : g_digit
    bcd_digit_counter u_digit (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_clear (w_clear),
      .i_inc   (w_inc[gi]),
      .o_digit (w_digit[gi]),
      .o_carry (w_inc[gi+1])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_freq  <= '0;
      r_digit <= '{default: '0};
      r_ovf   <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= (r_state == LATCH);
      if (r_state == LATCH) begin
        r_freq  <= r_work;
        r_digit <= w_digit;
        r_ovf   <= r_work_ovf;
      end
    end
  end

  assign frequency      = r_freq;
  assign digit_one      = r_digit[0];
  assign digit_ten      = r_digit[1];
  assign digit_hundred  = r_digit[2];
  assign digit_thousand = r_digit[3];
  assign overflow       = r_ovf;
  assign valid          = r_valid;
endmodule

// File: tb/tb_freq_meter.sv
// tb/tb_freq_meter.sv - randomized self-checking bench for freq_meter
module tb_freq_meter;
  localparam int GS   = 1000;
  localparam int GB   = 20200;
  localparam int MAXC = 9999;
`ifdef FREQ_METER_DEGLITCH_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, en_s, en_b, sig_in;
  logic [16:0] freq_s, freq_b;
  logic [3:0]  d1_s, d10_s, d100_s, d1000_s;
  logic [3:0]  d1_b, d10_b, d100_b, d1000_b;
  logic        ovf_s, ovf_b, valid_s, valid_b;

  freq_meter #(.GATE_CYCLES(GS)) u_dut_s (
    .clk(clk), .rst_n(rst_n), .enable(en_s), .sig_in(sig_in),
    .frequency(freq_s), .digit_one(d1_s), .digit_ten(d10_s),
    .digit_hundred(d100_s), .digit_thousand(d1000_s),
    .overflow(ovf_s), .valid(valid_s)
  );

  freq_meter #(.GATE_CYCLES(GB)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .enable(en_b), .sig_in(sig_in),
    .frequency(freq_b), .digit_one(d1_b), .digit_ten(d10_b),
    .digit_hundred(d100_b), .digit_thousand(d1000_b),
    .overflow(ovf_b), .valid(valid_b)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  bit s_hist [0:65535];
  int gen_mode = 0;
  int period   = 10;
  int phase    = 0;
  int sel      = 0;
  int exp_freq = 0;
  bit en_drv   = 1'b0;
  bit rst_drv  = 1'b0;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int o_freq();
    return sel ? int'(freq_b) : int'(freq_s);
  endfunction
  function automatic int o_valid();
    return sel ? int'(valid_b) : int'(valid_s);
  endfunction
  function automatic int o_ovf();
    return sel ? int'(ovf_b) : int'(ovf_s);
  endfunction
  function automatic int o_digit(input int i);
    case (i)
      0:       return sel ? int'(d1_b)    : int'(d1_s);
      1:       return sel ? int'(d10_b)   : int'(d10_s);
      2:       return sel ? int'(d100_b)  : int'(d100_s);
      default: return sel ? int'(d1000_b) : int'(d1000_s);
    endcase
  endfunction

  // Signal level as seen by the counting logic for input sample k.
  function automatic bit lvl(input int k);
    if (k < 2) return 1'b0;
`ifdef FREQ_METER_DEGLITCH_EN
    return (int'(s_hist[k]) + int'(s_hist[k-1]) + int'(s_hist[k-2])) >= 2;
`else
    return s_hist[k];
`endif
  endfunction

  // Rising edges whose count lands inside the gate that started at edge e.
  function automatic int model_count(input int e, input int g);
    int cnt = 0;
    for (int k = e - LAT; k <= e + g - 1 - LAT; k++)
      if (lvl(k) && !lvl(k - 1)) cnt++;
    return cnt;
  endfunction

  task automatic step();
    bit s;
    case (gen_mode)
      1:       s = ((cyc + 1 + phase) % period) < (period / 2);
      2:       s = 1'($urandom_range(0, 1));
      3:       s = ((cyc + 1) % 20) == 0;
      default: s = 1'b0;
    endcase
    sig_in = s;
    rst_n  = rst_drv;
    en_s   = en_drv && (sel == 0);
    en_b   = en_drv && (sel == 1);
    @(posedge clk);
    cyc++;
    s_hist[cyc] = rst_drv ? s : 1'b0;
    #1;
  endtask

  task automatic check_outputs(input string tag, input int f, input int ov);
    check_eq({tag, ".freq"}, o_freq(), f);
    check_eq({tag, ".one"}, o_digit(0), f % 10);
    check_eq({tag, ".ten"}, o_digit(1), (f / 10) % 10);
    check_eq({tag, ".hundred"}, o_digit(2), (f / 100) % 10);
    check_eq({tag, ".thousand"}, o_digit(3), f / 1000);
    check_eq({tag, ".ovf"}, o_ovf(), ov);
  endtask

  task automatic measure(input int g, input int gates, input bit keep, input string tag);
    int e, vcyc, cnt, f;
    en_drv = 1'b1;
    step();
    e = cyc;
    for (int gi = 0; gi < gates; gi++) begin
      vcyc = -1;
      for (int t = 0; t < g + 5 && vcyc < 0; t++) begin
        step();
        if (o_valid() != 0) vcyc = cyc;
      end
      check_eq({tag, ".vtime"}, vcyc - e, g + 1);
      cnt = model_count(e, g);
      f = (cnt > MAXC) ? MAXC : cnt;
      check_outputs(tag, f, (cnt > MAXC) ? 1 : 0);
      exp_freq = f;
      step();
      check_eq({tag, ".vpulse"}, o_valid(), 0);
      e = (vcyc >= 0) ? vcyc : cyc;
    end
    if (!keep) begin
      en_drv = 1'b0;
      step();
      step();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int nval;
    rst_drv = 1'b0;
    en_drv  = 1'b0;
    repeat (3) step();
    for (int i = 0; i < 2; i++) begin
      sel = i;
      check_outputs("reset", 0, 0);
      check_eq("reset.valid", o_valid(), 0);
    end
    sel = 0;
    rst_drv = 1'b1;
    repeat (3) step();

    gen_mode = 1; period = 10; phase = 0;
    measure(GS, 2, 1'b0, "p10");
    gen_mode = 2;
    measure(GS, 1, 1'b0, "rand");
    gen_mode = 1; period = $urandom_range(3, 40); phase = $urandom_range(0, 39);
    measure(GS, 1, 1'b0, "rper");
    gen_mode = 0;
    measure(GS, 1, 1'b0, "low");
    gen_mode = 3;
    measure(GS, 1, 1'b0, "pulse");

    gen_mode = 1; period = 10; phase = $urandom_range(0, 9);
    measure(GS, 1, 1'b1, "abort1");
    repeat (GS / 2) step();
    en_drv = 1'b0;
    nval = 0;
    repeat (GS + 20) begin
      step();
      if (o_valid() != 0) nval++;
    end
    check_eq("abort.nvalid", nval, 0);
    check_eq("abort.hold", o_freq(), exp_freq);
    period = 7;
    measure(GS, 1, 1'b0, "abort2");

    period = 10;
    measure(GS, 1, 1'b1, "rst1");
    repeat (300) step();
    gen_mode = 0;
    repeat (3) step();
    rst_drv = 1'b0;
    step();
    rst_drv = 1'b1;
    check_outputs("midrst", 0, 0);
    check_eq("midrst.valid", o_valid(), 0);
    gen_mode = 1;
    measure(GS, 1, 1'b0, "rst2");

    sel = 1;
    period = 2; phase = 0;
    measure(GB, 1, 1'b0, "sat");
    period = 10;
    measure(GB, 1, 1'b0, "unsat");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
